// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line settings and the
// command byte codes understood by the Bluetooth command decoder.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_DEFAULT     = 9600;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  localparam logic [7:0] CMD_PRE_CMD = 8'h00;
  localparam logic [7:0] CMD_PAUSE   = 8'h01;
  localparam logic [7:0] CMD_NEXT    = 8'h02;
  localparam logic [7:0] CMD_PREV    = 8'h03;
  localparam logic [7:0] CMD_VOL_UP  = 8'h04;
  localparam logic [7:0] CMD_VOL_DN  = 8'h05;
  localparam logic [7:0] CMD_FX0     = 8'h40;
  localparam logic [7:0] CMD_FX1     = 8'h41;
  localparam logic [7:0] CMD_FX2     = 8'h42;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so idle-high lines (UART rx, pulled-up buttons) come out of reset inactive.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 3-sample majority voting, start-glitch rejection and
// stop-bit checking; emits one-cycle done / frame-error strobes.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD     = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(HALF + 1);

  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_adv;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ferr;
  logic             w_ferr_nxt;
  logic             r_smp0;
  logic             r_smp1;
  logic             r_rx_prev;
  logic [1:0]       r_flush;

  logic w_rx_s;
  logic w_fall;
  logic w_eval;
  logic w_maj;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // r_rx_prev stays 0 until the synchronizer holds real line samples, so a line
  // that is already low at reset release needs a genuine 1->0 before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush   <= 2'b00;
      r_rx_prev <= 1'b0;
    end else begin
      r_flush   <= {r_flush[0], 1'b1};
      r_rx_prev <= r_flush[1] ? w_rx_s : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp0 <= 1'b1;
      r_smp1 <= 1'b1;
    end else begin
      if (r_cnt == CNT_S0) r_smp0 <= w_rx_s;
      if (r_cnt == CNT_S1) r_smp1 <= w_rx_s;
    end
  end

  assign w_fall    = r_rx_prev & ~w_rx_s;
  assign w_eval    = (r_cnt == CNT_S2);
  // Third vote is the live sample taken in the evaluation cycle itself.
  assign w_maj     = maj3(r_smp0, r_smp1, w_rx_s);
  assign w_cnt_adv = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (w_fall) w_state_nxt = StStart;
      end
      StStart: begin
        w_cnt_nxt = w_cnt_adv;
        if (w_eval && w_maj) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = StData;
          w_idx_nxt   = '0;
        end
      end
      StData: begin
        w_cnt_nxt = w_cnt_adv;
        if (w_eval) w_shift_nxt[r_idx] = w_maj;
        if (r_cnt == CNT_LAST) begin
          if (r_idx == 3'd7) w_state_nxt = StStop;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      StStop: begin
        w_cnt_nxt = w_cnt_adv;
        // Decide mid-stop-bit so a following start edge lands while in IDLE.
        if (w_eval) begin
          w_cnt_nxt = '0;
          if (w_maj) begin
            w_data_nxt  = r_shift;
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = StBreak;
          end
        end
      end
      StBreak: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign o_data      = r_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed and random 8N1 frames checked
// against a frame-level model of what the receiver must deliver.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 640_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int          CPB      = CLK_FREQ / BAUD;
  localparam int          HALF     = CPB / 2;
  localparam int          CPB_SLOW = 66;
  localparam int          CPB_FAST = 62;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: record every strobe with a cycle stamp.
  logic [7:0] done_q[$];
  int         done_t[$];
  int         cyc       = 0;
  int         ferr_n    = 0;
  int         overlap_n = 0;
  int         busy_n    = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (o_rx_done) begin
        done_q.push_back(o_data);
        done_t.push_back(cyc);
      end
      if (o_frame_err) ferr_n <= ferr_n + 1;
      if (o_rx_done && o_frame_err) overlap_n <= overlap_n + 1;
      if (o_busy) busy_n <= busy_n + 1;
    end
  end

  // Reference model: bytes that must appear, last good byte, frame errors.
  logic [7:0] exp_q[$];
  logic [7:0] m_data = 8'h00;
  int         m_ferr = 0;
  int         seen   = 0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_cycles(n * CPB);
  endtask

  task automatic tx_frame(input logic [7:0] d, input logic stop, input int cpb);
    rx = 1'b0;
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(cpb);
    end
    rx = stop;
    wait_cycles(cpb);
    if (stop) begin
      exp_q.push_back(d);
      m_data = d;
    end else begin
      m_ferr++;
    end
  endtask

  task automatic check_frames(input string tag);
    int got;
    got = done_q.size() - seen;
    check({tag, "_done_count"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++)
      check({tag, "_byte"}, int'(done_q[seen + i]), int'(exp_q[i]));
    check({tag, "_ferr_count"}, ferr_n, m_ferr);
    check({tag, "_overlap"}, overlap_n, 0);
    check({tag, "_o_data"}, int'(o_data), int'(m_data));
    seen = done_q.size();
    exp_q.delete();
  endtask

  initial begin
    int b;
    int busy0;
    logic [7:0] d33;

    rst_n = 1'b0;
    rx    = 1'b1;
    wait_cycles(3);
    check("rst_data", int'(o_data), 0);
    check("rst_done", int'(o_rx_done), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    check("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    idle_bits(1);

    // Single nominal frame and busy duration (~9.5 bit times).
    busy0 = busy_n;
    tx_frame(CMD_NEXT, 1'b1, CPB);
    idle_bits(1);
    check_range("busy_len", busy_n - busy0, (19 * CPB) / 2 - 8, (19 * CPB) / 2 + 8);
    check_frames("single");

    // Back-to-back frames with no idle gap.
    b = done_q.size();
    tx_frame(CMD_FX1, 1'b1, CPB);
    tx_frame(CMD_VOL_DN, 1'b1, CPB);
    idle_bits(1);
    if (done_q.size() >= b + 2)
      check_range("b2b_spacing", done_t[b + 1] - done_t[b], 10 * CPB - 2, 10 * CPB + 2);
    check_frames("b2b");

    // Short low glitch on an idle line.
    rx = 1'b0;
    wait_cycles(10);
    check("glitch_busy_seen", int'(o_busy), 1);
    wait_cycles(10);
    rx = 1'b1;
    wait_cycles(HALF + 10 - 20);
    check("glitch_back_idle", int'(o_busy), 0);
    idle_bits(1);
    check_frames("glitch");

    // Bad stop bit, line held low: one error then silence until a valid frame.
    tx_frame(8'hA5, 1'b0, CPB);
    wait_cycles(3 * CPB);
    check("break_busy", int'(o_busy), 1);
    idle_bits(2);
    check("break_exit_idle", int'(o_busy), 0);
    check_frames("ferr");
    tx_frame(CMD_FX0, 1'b1, CPB);
    idle_bits(1);
    check_frames("after_ferr");

    // Reset during data bit 4 of 8'h33.
    d33 = 8'h33;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d33[i];
      wait_cycles(CPB);
    end
    rx = d33[4];
    wait_cycles(HALF);
    rst_n = 1'b0;
    wait_cycles(3);
    m_data = 8'h00;
    check("midrst_data", int'(o_data), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_done", int'(o_rx_done), 0);
    rx = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    idle_bits(1);
    tx_frame(CMD_VOL_UP, 1'b1, CPB);
    idle_bits(1);
    check_frames("midrst");

    // Reset released while the line is already low: not a start bit.
    rst_n = 1'b0;
    rx    = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    m_data = 8'h00;
    wait_cycles(3 * CPB);
    check("low_release_busy", int'(o_busy), 0);
    check_frames("low_release");
    idle_bits(1);
    tx_frame(CMD_FX2, 1'b1, CPB);
    idle_bits(1);
    check_frames("after_low_release");

    // Transmitter rate error of about +/-3%.
    tx_frame(8'h55, 1'b1, CPB_SLOW);
    idle_bits(1);
    tx_frame(8'hFF, 1'b1, CPB_FAST);
    idle_bits(1);
    check_frames("rate");

    // Random bytes, rates and gaps.
    for (int k = 0; k < 8; k++) begin
      tx_frame(8'($urandom), 1'b1, int'($urandom_range(CPB_FAST, CPB_SLOW)));
      idle_bits(int'($urandom_range(0, 1)));
    end
    idle_bits(1);
    check_frames("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- 8N1 UART receiver that turns the Bluetooth module's serial line (HC-05 class, 9600 baud) into bytes plus a one-cycle valid strobe.
- Directly feeds the Bluetooth command decoder, which latches a byte as a command code when o_rx_done is high.
- Adds glitch rejection, 3-sample majority voting and stop-bit checking, so a noisy line cannot inject false commands.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, 10416 at defaults), clock cycles per bit. Derived; do not override.
- HALF, CLKS_PER_BIT/2, cycle offset of the mid-bit sample. Derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- rx  in  1  raw asynchronous serial input; idles high.
- o_data  out  8  last correctly received byte, LSB first on the line; held until the next good byte.
- o_rx_done  out  1  one-cycle pulse; o_data is valid and new in that same cycle.
- o_frame_err  out  1  one-cycle pulse on a bad stop bit.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: o_data=8'h00, o_rx_done=0, o_frame_err=0, o_busy=0, FSM=IDLE, bit counter=0, cycle counter=0. Both synchronizer flops reset to 1.
- Input conditioning: rx passes through a 2-FF synchronizer to give rx_s. All decisions use rx_s; there are 2 cycles of input latency.
- Cycle counter: runs 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at a bit boundary. Width is clog2(CLKS_PER_BIT).
- Majority sample: rx_s is captured at counter values HALF-1, HALF and HALF+1. The bit value is the majority of the 3, evaluated at HALF+1.
- IDLE:
  - Falling edge on rx_s (previous 1, current 0) -> START; cycle counter cleared to 0.
  - o_busy goes high in the cycle after the edge is detected.
- START:
  - Majority = 1 at HALF+1 -> glitch: return to IDLE with no outputs pulsed.
  - Majority = 0 -> stay until counter = CLKS_PER_BIT-1, then -> DATA with bit index = 0.
- DATA:
  - At HALF+1 the majority value is shifted into the shift register at position bit index (LSB first).
  - At CLKS_PER_BIT-1 the bit index increments. After index 7 completes -> STOP.
- STOP: evaluated at HALF+1, not at the end of the bit, so a byte can start immediately after the stop bit.
  - Majority = 1: o_data <= shift register, o_rx_done=1 for exactly one cycle (the cycle after evaluation), -> IDLE.
  - Majority = 0: o_frame_err=1 for one cycle, o_data unchanged, -> BREAK.
- BREAK: wait until rx_s = 1, then -> IDLE. This stops a held-low line from producing repeated frames.
- Pulse and busy rules:
  - o_rx_done and o_frame_err are never high together, and neither is high for more than one cycle per frame.
  - o_busy falls in the same cycle that o_rx_done or o_frame_err pulses, or that a START glitch abort happens.
- Back-to-back frames: a start edge that arrives while IDLE is being re-entered must be caught. Edge detection in IDLE compares against the previous rx_s sample, which is maintained in every state.
- Reset mid-frame: outputs return to reset values immediately and the partial byte is discarded. After release, a line that is already low is not treated as a start bit until a 1->0 transition is seen.
- Baud tolerance: frames must decode correctly with up to ±3% transmitter rate error at defaults.

Decomposition:
- Shared package uart_pkg holds:
  - rx FSM state encoding: IDLE, START, DATA, STOP, BREAK.
  - Default CLK_FREQ and BAUD.
  - Command byte constants used by the downstream decoder: 8'h00 cmd_pre, 8'h01 pause, 8'h02 next, 8'h03 pre, 8'h04 vol+, 8'h05 vol-, 8'h40/41/42 effects. Keeping them here puts the bench and the decoder on one source.
- One natural sub-module: sync_2ff (1-bit, reset value parameter), also reusable for button inputs.

Test Plan:
- Send 8'h02 at nominal baud -> exactly one o_rx_done pulse with o_data=8'h02; o_frame_err stays 0; o_busy high for about 9.5 bit times.
- Send 8'h41 then 8'h05 back-to-back, no idle gap -> two o_rx_done pulses with o_data 8'h41 then 8'h05; pulse spacing is 10 bit times ±2 cycles.
- Drive a 2000-cycle low glitch on an idle line -> no o_rx_done, no o_frame_err; FSM back in IDLE before HALF+2 cycles.
- Send 8'hA5 with stop bit = 0 and the line held low for 3 bit times -> one o_frame_err pulse, o_data keeps its previous value, no further pulses until rx goes high and a new valid frame arrives.
- Assert rst_n low during data bit 4 of 8'h33, release with the line high, then send 8'h04 -> o_data is 8'h00 after reset, then a single o_rx_done with 8'h04.
- Send 8'h55 and 8'hFF at baud +3% and -3% -> both decode correctly with one pulse each.
